// File: rtl/sys_xbar_rr.sv
// Address-decoded shared bus: round-robin arbitration with a bounded grant-hold,
// per-slave base/mask decode and an RD_LAT-deep read-return pipeline.
module sys_xbar_rr #(
  parameter int                      XLEN     = 32,
  parameter int                      N_MST    = 4,
  parameter int                      N_SLV    = 6,
  parameter logic [N_SLV*XLEN-1:0]   SLV_BASE = {N_SLV{32'h0}},
  parameter logic [N_SLV*XLEN-1:0]   SLV_MASK = {N_SLV{32'hFFFF_F000}},
  parameter int                      RD_LAT   = 1,
  parameter int                      MAX_HOLD = 16,
  parameter logic [XLEN-1:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_MST-1:0]        i_req,
  output logic [N_MST-1:0]        o_gnt,
  input  logic [N_MST*XLEN-1:0]   i_m_addr,
  input  logic [N_MST-1:0]        i_m_write,
  input  logic [N_MST-1:0]        i_m_read,
  input  logic [N_MST*4-1:0]      i_m_size,
  input  logic [N_MST*XLEN-1:0]   i_m_din,
  output logic [N_MST*XLEN-1:0]   o_m_dout,
  output logic [N_MST-1:0]        o_m_rvalid,
  output logic [N_MST-1:0]        o_m_err,
  output logic [N_SLV*XLEN-1:0]   o_s_addr,
  output logic [N_SLV-1:0]        o_s_write,
  output logic [N_SLV-1:0]        o_s_read,
  output logic [N_SLV*4-1:0]      o_s_size,
  output logic [N_SLV*XLEN-1:0]   o_s_din,
  input  logic [N_SLV*XLEN-1:0]   i_s_dout
);

  localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef struct packed {
    logic          vld;
    logic [MW-1:0] mst;
    logic [SW-1:0] slv;
    logic          miss;
  } rd_ent_t;

  logic [MW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [MW-1:0] owner_q, owner_d;
  logic          owner_vld_q, owner_vld_d;
  rd_ent_t       pipe_q [RD_LAT];
  rd_ent_t       pipe_d [RD_LAT];

  logic             keep;
  logic [N_MST-1:0] owner_oh;
  logic             gnt_vld;
  logic [MW-1:0]    gnt_idx;

  function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_MST) s = s - N_MST;
    return MW'(s);
  endfunction

  // The current owner keeps the bus until its hold budget runs out, unless nobody else wants it.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    owner_oh = N_MST'(1) << owner_q;
    keep     = owner_vld_q && i_req[owner_q] &&
               ((hold_cnt_q < HOLD_MAX) || (i_req == owner_oh));
    if (keep) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int i = N_MST - 1; i >= 0; i--) begin
        if (i_req[rr_idx(rr_ptr_q, i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx(rr_ptr_q, i);
        end
      end
    end
    if (i_rst) gnt_vld = 1'b0;
  end

  assign o_gnt = gnt_vld ? (N_MST'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = '0;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    if (gnt_vld) begin
      owner_vld_d = 1'b1;
      owner_d     = gnt_idx;
      rr_ptr_d    = (gnt_idx == MW'(N_MST - 1)) ? '0 : gnt_idx + 1'b1;
      if (owner_vld_q && (gnt_idx == owner_q))
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 1'b1;
      else
        hold_cnt_d = HW'(1);
    end
  end

  // Command path: the granted master drives every slave; only the decoded slave sees a strobe.
  logic [XLEN-1:0]  sel_addr, sel_din;
  logic [3:0]       sel_size;
  logic             sel_wr, sel_rd;
  logic [N_SLV-1:0] hit;
  logic             dec_hit;
  logic [SW-1:0]    dec_idx;

  assign sel_addr = gnt_vld ? i_m_addr[int'(gnt_idx)*XLEN +: XLEN] : '0;
  assign sel_din  = gnt_vld ? i_m_din[int'(gnt_idx)*XLEN +: XLEN] : '0;
  assign sel_size = gnt_vld ? i_m_size[int'(gnt_idx)*4 +: 4] : '0;
  assign sel_wr   = gnt_vld && i_m_write[gnt_idx];
  assign sel_rd   = gnt_vld && i_m_read[gnt_idx] && !i_m_write[gnt_idx];

  generate
    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_slv
      assign hit[gi] = (sel_addr & SLV_MASK[gi*XLEN +: XLEN]) ==
                       (SLV_BASE[gi*XLEN +: XLEN] & SLV_MASK[gi*XLEN +: XLEN]);
      assign o_s_addr[gi*XLEN +: XLEN] = sel_addr;
      assign o_s_din[gi*XLEN +: XLEN]  = sel_din;
      assign o_s_size[gi*4 +: 4]       = sel_size;
      assign o_s_write[gi] = sel_wr && dec_hit && (dec_idx == SW'(gi));
      assign o_s_read[gi]  = sel_rd && dec_hit && (dec_idx == SW'(gi));
    end
  endgenerate

  always_comb begin
    dec_hit = |hit;
    dec_idx = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (hit[k]) dec_idx = SW'(k);
    end
  end

  always_comb begin
    pipe_d[0].vld  = sel_rd;
    pipe_d[0].mst  = gnt_idx;
    pipe_d[0].slv  = dec_idx;
    pipe_d[0].miss = !dec_hit;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Return stage: masked during reset so a read issued just before reset never completes.
  rd_ent_t          ret;
  logic             ret_vld;
  logic [XLEN-1:0]  ret_data;
  logic [N_MST-1:0] rv;

  assign ret      = pipe_q[RD_LAT-1];
  assign ret_vld  = ret.vld && !i_rst;
  assign ret_data = ret.miss ? ERR_DATA : i_s_dout[int'(ret.slv)*XLEN +: XLEN];

  generate
    for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
      assign rv[gi]                    = ret_vld && (ret.mst == MW'(gi));
      assign o_m_rvalid[gi]            = rv[gi];
      assign o_m_err[gi]               = rv[gi] && ret.miss;
      assign o_m_dout[gi*XLEN +: XLEN] = rv[gi] ? ret_data : '0;
    end
  endgenerate

endmodule

// File: tb/tb_sys_xbar_rr.sv
// Directed bench for sys_xbar_rr: two instances (RD_LAT=1/MAX_HOLD=1 and RD_LAT=2/MAX_HOLD=16)
// share stimulus; read returns are predicted into a scoreboard queue and checked every cycle.
module tb_sys_xbar_rr;

  localparam logic [191:0] BASES = {32'h8000_0000, 32'h8000_0000, 32'h5000_0000,
                                    32'h4000_1000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [191:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_F000,
                                    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic         clk;
  logic         i_rst;
  logic [3:0]   req, m_write, m_read;
  logic [127:0] m_addr, m_din;
  logic [15:0]  m_size;
  logic [191:0] s_dout;
  logic [31:0]  cyc = '0;

  logic [3:0]   gnt_a, rv_a, err_a, gnt_b, rv_b, err_b;
  logic [127:0] dout_a, dout_b;
  logic [191:0] s_addr_a, s_din_a, s_addr_b, s_din_b;
  logic [5:0]   s_write_a, s_read_a, s_write_b, s_read_b;
  logic [23:0]  s_size_a, s_size_b;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    logic [31:0] due;
    int          mst;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  sys_xbar_rr #(.N_MST(4), .N_SLV(6), .SLV_BASE(BASES), .SLV_MASK(MASKS),
                .RD_LAT(1), .MAX_HOLD(1)) u_a (
    .i_clk(clk), .i_rst(i_rst), .i_req(req), .o_gnt(gnt_a),
    .i_m_addr(m_addr), .i_m_write(m_write), .i_m_read(m_read), .i_m_size(m_size),
    .i_m_din(m_din), .o_m_dout(dout_a), .o_m_rvalid(rv_a), .o_m_err(err_a),
    .o_s_addr(s_addr_a), .o_s_write(s_write_a), .o_s_read(s_read_a),
    .o_s_size(s_size_a), .o_s_din(s_din_a), .i_s_dout(s_dout));

  sys_xbar_rr #(.N_MST(4), .N_SLV(6), .SLV_BASE(BASES), .SLV_MASK(MASKS),
                .RD_LAT(2), .MAX_HOLD(16)) u_b (
    .i_clk(clk), .i_rst(i_rst), .i_req(req), .o_gnt(gnt_b),
    .i_m_addr(m_addr), .i_m_write(m_write), .i_m_read(m_read), .i_m_size(m_size),
    .i_m_din(m_din), .o_m_dout(dout_b), .o_m_rvalid(rv_b), .o_m_err(err_b),
    .o_s_addr(s_addr_b), .o_s_write(s_write_b), .o_s_read(s_read_b),
    .o_s_size(s_size_b), .o_s_din(s_din_b), .i_s_dout(s_dout));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Slave k returns {A0+k, cycle}, so data identifies both the slave and the return cycle.
  always_comb begin
    s_dout = '0;
    for (int k = 0; k < 6; k++) s_dout[k*32 +: 32] = {8'hA0 + 8'(k), cyc[23:0]};
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic check_ret();
    logic [3:0]   v0, v1, e0, e1;
    logic [127:0] d0, d1;
    v0 = '0; v1 = '0; e0 = '0; e1 = '0; d0 = '0; d1 = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        if (sb[i].inst == 0) begin
          v0[sb[i].mst] = 1'b1; e0[sb[i].mst] = sb[i].err; d0[sb[i].mst*32 +: 32] = sb[i].data;
        end else begin
          v1[sb[i].mst] = 1'b1; e1[sb[i].mst] = sb[i].err; d1[sb[i].mst*32 +: 32] = sb[i].data;
        end
        sb.delete(i);
      end
    end
    chk("rvalid_a", 256'(rv_a), 256'(v0));
    chk("err_a", 256'(err_a), 256'(e0));
    chk("dout_a", 256'(dout_a), 256'(d0));
    chk("rvalid_b", 256'(rv_b), 256'(v1));
    chk("err_b", 256'(err_b), 256'(e1));
    chk("dout_b", 256'(dout_b), 256'(d1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_ret();
  endtask

  task automatic tick_rst();
    @(posedge clk);
    #1;
    i_rst = 1'b1;
    clear_in();
    #1;
    check_ret();
  endtask

  task automatic clear_in();
    req = '0; m_write = '0; m_read = '0; m_addr = '0; m_size = '0; m_din = '0;
  endtask

  task automatic push_rd(input int m, input int k);
    exp_t e;
    for (int inst = 0; inst < 2; inst++) begin
      e.inst = inst;
      e.due  = cyc + 32'(inst + 1);
      e.mst  = m;
      e.err  = (k < 0);
      e.data = (k < 0) ? 32'hDEAD_BEEF : {8'hA0 + 8'(k), e.due[23:0]};
      sb.push_back(e);
    end
  endtask

  // Single-master read: checks grant and read strobe now, predicts the return.
  task automatic do_read(input int m, input logic [31:0] addr, input int k, input bit push);
    logic [3:0] oh;
    logic [5:0] sr;
    clear_in();
    req[m] = 1'b1; m_read[m] = 1'b1; m_addr[m*32 +: 32] = addr; m_size[m*4 +: 4] = 4'hF;
    #1;
    oh = 4'b0001 << m;
    sr = (k < 0) ? 6'b0 : (6'b000001 << k);
    chk("rd_gnt_a", 256'(gnt_a), 256'(oh));
    chk("rd_gnt_b", 256'(gnt_b), 256'(oh));
    chk("rd_sread_a", 256'(s_read_a), 256'(sr));
    chk("rd_sread_b", 256'(s_read_b), 256'(sr));
    chk("rd_swrite_a", 256'(s_write_a), 256'(0));
    $display("[TB] read m=%0d addr=%h slave=%0d cycle=%0d", m, addr, k, cyc);
    if (push) push_rd(m, k);
  endtask

  initial begin
    logic [3:0] exp_g;
    i_rst = 1'b1;
    clear_in();
    tick(); tick(); tick();

    // Reset: no grant even with every master requesting.
    req = 4'hF;
    #1;
    chk("rst_gnt_a", 256'(gnt_a), 256'(0));
    chk("rst_gnt_b", 256'(gnt_b), 256'(0));

    // Rotation: MAX_HOLD=1 rotates 0,1,2,3; MAX_HOLD=16 keeps master 0.
    i_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = 4'b0001 << (i % 4);
      chk("rot_gnt_a", 256'(gnt_a), 256'(exp_g));
      chk("rot_gnt_b", 256'(gnt_b), 256'(4'b0001));
      $display("[TB] rotate cycle=%0d gnt_a=%b gnt_b=%b", i, gnt_a, gnt_b);
      tick();
    end

    // Idle bus.
    clear_in();
    #1;
    chk("idle_gnt", 256'(gnt_a), 256'(0));
    chk("idle_saddr", 256'(s_addr_a), 256'(0));
    chk("idle_sdin", 256'(s_din_a), 256'(0));
    chk("idle_ssize", 256'(s_size_a), 256'(0));
    chk("idle_strobes", 256'({s_read_a, s_write_a}), 256'(0));
    tick();

    // Hold: master 2 alone for one cycle, then masters 1 and 2 together.
    for (int i = 0; i < 40; i++) begin
      req = (i == 0) ? 4'b0100 : 4'b0110;
      #1;
      exp_g = (i < 16) ? 4'b0100 : (i < 32) ? 4'b0010 : 4'b0100;
      chk("hold_gnt_b", 256'(gnt_b), 256'(exp_g));
      exp_g = (i % 2 == 0) ? 4'b0100 : 4'b0010;
      chk("hold_gnt_a", 256'(gnt_a), 256'(exp_g));
      $display("[TB] hold cycle=%0d gnt_a=%b gnt_b=%b", i, gnt_a, gnt_b);
      tick();
    end
    clear_in();
    tick();

    // Single read to slave 1.
    do_read(0, 32'h4000_0100, 1, 1'b1);
    chk("rd_saddr1", 256'(s_addr_a[32 +: 32]), 256'(32'h4000_0100));
    tick(); clear_in(); tick(); tick();

    // Unmapped read returns ERR_DATA with err.
    do_read(1, 32'h1234_0000, -1, 1'b1);
    tick(); clear_in(); tick(); tick();

    // Overlapping decode: lowest slave index wins.
    do_read(2, 32'h8000_0010, 4, 1'b1);
    tick();
    do_read(2, 32'h8100_0000, 5, 1'b1);
    tick(); clear_in(); tick(); tick();

    // Back-to-back reads from masters 0 then 3.
    do_read(0, 32'h4000_0100, 1, 1'b1);
    tick();
    do_read(3, 32'h5000_0008, 3, 1'b1);
    tick(); clear_in(); tick(); tick(); tick();

    // Writes: hit, miss (dropped), and read+write treated as write.
    clear_in();
    req[1] = 1'b1; m_write[1] = 1'b1; m_addr[32 +: 32] = 32'h4000_1004;
    m_din[32 +: 32] = 32'h1234_5678; m_size[4 +: 4] = 4'h3;
    #1;
    $display("[TB] write m=1 addr=40001004 cycle=%0d", cyc);
    chk("wr_swrite", 256'(s_write_a), 256'(6'b000100));
    chk("wr_sread", 256'(s_read_a), 256'(0));
    chk("wr_sdin2", 256'(s_din_a[64 +: 32]), 256'(32'h1234_5678));
    chk("wr_saddr0", 256'(s_addr_a[0 +: 32]), 256'(32'h4000_1004));
    chk("wr_ssize5", 256'(s_size_b[20 +: 4]), 256'(4'h3));
    tick();
    m_addr[32 +: 32] = 32'h1234_0000;
    #1;
    $display("[TB] write m=1 addr=12340000 cycle=%0d", cyc);
    chk("wrmiss_swrite", 256'(s_write_a), 256'(0));
    chk("wrmiss_gnt", 256'(gnt_a), 256'(4'b0010));
    tick();
    clear_in();
    req[3] = 1'b1; m_write[3] = 1'b1; m_read[3] = 1'b1; m_addr[96 +: 32] = 32'h5000_0008;
    #1;
    $display("[TB] read+write m=3 addr=50000008 cycle=%0d", cyc);
    chk("rw_swrite", 256'(s_write_b), 256'(6'b001000));
    chk("rw_sread", 256'(s_read_b), 256'(0));
    tick(); clear_in(); tick(); tick();

    // Reset one cycle after a granted read: return discarded, arbitration restarts at 0.
    do_read(2, 32'h4000_0100, 1, 1'b0);
    tick_rst();
    tick();
    i_rst = 1'b0;
    req = 4'hF;
    #1;
    chk("postrst_gnt_a", 256'(gnt_a), 256'(4'b0001));
    chk("postrst_gnt_b", 256'(gnt_b), 256'(4'b0001));
    tick();
    clear_in();
    tick(); tick();

    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
